op_issue_queue: RTL and testbench

//  Buffers `operation` words from the host/sequencer and issues them one at a time to cpu.op.

---
 rtl/op_issue_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_op_issue_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issue_queue.sv
// -----------------------------------------------------------------------------
// op_issue_queue
//
// Buffers `operation` words from the host/sequencer and issues them one at a
// time to the cpu. Between issues cpu_op carries NO_OP with all fields zero.
// After an issue the queue waits for cpu_done, then spends one settle cycle
// (writeback) before the next issue. The result is in-order, single-in-flight
// execution with backpressure to the producer.
//
// Parameters
//   DEPTH    queue entries (power of two, >= 2)
//   TIMEOUT  maximum WAIT cycles before the watchdog fires (timeout build only)
//
// Ports
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous, active-high
//   enq_valid    in   producer presents an op on enq_op
//   enq_op       in   op struct (mode, idx1_a/b, idx2_a/b, out_a/b)
//   enq_ready    out  queue can accept (count < DEPTH)
//   cpu_op       out  op to the cpu; NO_OP/zero except for one cycle per issue
//   cpu_done     in   completion strobe from the cpu
//   busy         out  op in flight or entries queued
//   count        out  occupied entries
//   retired_cnt  out  ops completed, wraps 0xFFFF -> 0
//   err_timeout  out  sticky watchdog flag
//
// Optional feature macro: ISSUE_TIMEOUT_EN
//   Defined   : 32-bit WAIT watchdog; on expiry err_timeout sets (sticky), the
//               op is abandoned without retiring and the queue keeps draining.
//   Undefined : WAIT holds indefinitely and err_timeout is constant 0.
// -----------------------------------------------------------------------------
package op_issue_queue_pkg;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        OP_CT_CT_ADD = 4'd1,
        OP_CT_PT_ADD = 4'd2,
        OP_CT_CT_MUL = 4'd3,
        OP_CT_PT_MUL = 4'd4
    } op_mode_e;

    typedef struct packed {
        op_mode_e   mode;
        logic [7:0] idx1_a;
        logic [7:0] idx1_b;
        logic [7:0] idx2_a;
        logic [7:0] idx2_b;
        logic [7:0] out_a;
        logic [7:0] out_b;
    } operation;

endpackage

module op_issue_queue
    import op_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid,
    input  operation                     enq_op,
    output logic                         enq_ready,
    output operation                     cpu_op,
    input  logic                         cpu_done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  retired_cnt,
    output logic                         err_timeout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam operation IDLE_OP = '{
        mode:   NO_OP,
        idx1_a: 8'd0,
        idx1_b: 8'd0,
        idx2_a: 8'd0,
        idx2_b: 8'd0,
        out_a:  8'd0,
        out_b:  8'd0
    };

    // An illegal DEPTH or TIMEOUT leaves this marker scope in the hierarchy.
    if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0) || (TIMEOUT < 32'd1)) begin : g_illegal_cfg
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    operation             mem_q [DEPTH];
    state_e               state_q,       state_d;
    logic [PTR_W-1:0]     wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]     count_q,       count_d;
    operation             cpu_op_q,      cpu_op_d;
    logic [15:0]          retired_q,     retired_d;
    logic                 enq_ready_q,   enq_ready_d;
    logic                 busy_q,        busy_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 push_s;
    logic                 pop_s;

`ifdef ISSUE_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 32'd1);
    logic [31:0]          wait_cnt_q,    wait_cnt_d;
    logic                 timed_out_q,   timed_out_d;
`endif

    // Next-state logic: queue bookkeeping, issue FSM and registered outputs.
    always_comb begin
        // NO_OP is accepted (handshake completes) but never written.
        push_s = enq_valid && enq_ready_q && (enq_op.mode != NO_OP);
        pop_s  = (state_q == ST_ISSUE);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        state_d       = state_q;
        cpu_op_d      = IDLE_OP;
        retired_d     = retired_q;
        err_timeout_d = err_timeout_q;
`ifdef ISSUE_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timed_out_d   = timed_out_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // cpu_op is registered, so the head appears on the port during
                // the first WAIT cycle; cpu_done is not looked at here.
                cpu_op_d = mem_q[rd_ptr_q];
                state_d  = ST_WAIT;
`ifdef ISSUE_TIMEOUT_EN
                wait_cnt_d  = 32'd0;
                timed_out_d = 1'b0;
`endif
            end
            ST_WAIT: begin
                if (cpu_done) begin
                    state_d = ST_SETTLE;
`ifdef ISSUE_TIMEOUT_EN
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_SETTLE;
                    timed_out_d   = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    state_d    = ST_WAIT;
`else
                end else begin
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_SETTLE: begin
`ifdef ISSUE_TIMEOUT_EN
                if (timed_out_q) begin
                    retired_d = retired_q;
                end else begin
                    retired_d = retired_q + 16'd1;
                end
`else
                retired_d = retired_q + 16'd1;
`endif
                // count_q already includes any enqueue written before this edge.
                if (count_q != CNT_ZERO) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enq_ready_d = (count_d < DEPTH_C);
        busy_d      = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= CNT_ZERO;
            cpu_op_q      <= IDLE_OP;
            retired_q     <= 16'd0;
            enq_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
            wait_cnt_q    <= 32'd0;
            timed_out_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cpu_op_q      <= cpu_op_d;
            retired_q     <= retired_d;
            enq_ready_q   <= enq_ready_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
`ifdef ISSUE_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timed_out_q   <= timed_out_d;
`endif
        end
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= enq_op;
        end
    end

    assign enq_ready   = enq_ready_q;
    assign cpu_op      = cpu_op_q;
    assign busy        = busy_q;
    assign count       = count_q;
    assign retired_cnt = retired_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_op_issue_queue.sv
module tb_op_issue_queue;
    import op_issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    operation    enq_op;
    logic        enq_ready;
    operation    cpu_op;
    logic        cpu_done;
    logic        busy;
    logic [3:0]  count;
    logic [15:0] retired_cnt;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    op_issue_queue #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_op      (enq_op),
        .enq_ready   (enq_ready),
        .cpu_op      (cpu_op),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .count       (count),
        .retired_cnt (retired_cnt),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic        ev;
        operation    op;
        logic        done;
        operation    exp_op;
        logic [3:0]  exp_cnt;
        logic        exp_rdy;
        logic        exp_busy;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic operation mk_op(input op_mode_e m, input int a, input int b,
                                       input int c, input int d, input int e, input int f);
        operation o;
        o.mode   = m;
        o.idx1_a = 8'(a);
        o.idx1_b = 8'(b);
        o.idx2_a = 8'(c);
        o.idx2_b = 8'(d);
        o.out_a  = 8'(e);
        o.out_b  = 8'(f);
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic ev, input operation op, input logic done,
                                    input operation exp_op, input int exp_cnt, input logic exp_rdy,
                                    input logic exp_busy, input int exp_ret);
        vec_t v;
        v.ev       = ev;
        v.op       = op;
        v.done     = done;
        v.exp_op   = exp_op;
        v.exp_cnt  = 4'(exp_cnt);
        v.exp_rdy  = exp_rdy;
        v.exp_busy = exp_busy;
        v.exp_ret  = 16'(exp_ret);
        return v;
    endfunction

    function automatic operation fill_op(input int i);
        return mk_op((i % 2 == 0) ? OP_CT_CT_MUL : OP_CT_PT_ADD, i + 1, i + 16, i + 32, i + 48, i + 64, i + 80);
    endfunction

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Waits (bounded) for a non-NO_OP issue and compares it with the expected op.
    task automatic wait_issue(input operation exp, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((cpu_op.mode == NO_OP) && (n < 12));
        check(name, 80'(cpu_op), 80'(exp));
    endtask

    // One-cycle cpu_done pulse while the queue sits in WAIT.
    task automatic complete();
        @(negedge clk) cpu_done = 1'b1;
        @(negedge clk) cpu_done = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_op"}, 80'(cpu_op), 80'(mk_op(NO_OP, 0, 0, 0, 0, 0, 0)));
        check({tag, "_count"}, 80'(count), 80'(4'd0));
        check({tag, "_enq_ready"}, 80'(enq_ready), 80'(1'b1));
        check({tag, "_busy"}, 80'(busy), 80'(1'b0));
        check({tag, "_retired"}, 80'(retired_cnt), 80'(16'd0));
        check({tag, "_err"}, 80'(err_timeout), 80'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        operation n_op;
        operation a_op;
        operation b_op;
        operation z_op;
        n_op = mk_op(NO_OP, 0, 0, 0, 0, 0, 0);
        a_op = mk_op(OP_CT_CT_ADD, 0, 1, 2, 3, 5, 6);
        b_op = mk_op(OP_CT_PT_ADD, 0, 1, 0, 4, 7, 8);
        z_op = mk_op(NO_OP, 9, 9, 9, 9, 9, 9);

        // Single op, done 4 cycles after it appears; done pulse in IDLE.
        vecs.push_back(mk_vec(1'b1, a_op, 1'b0, n_op, 1, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 1, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, a_op, 0, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, n_op, 0, 1'b1, 1'b1, 0));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b0, 1));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, n_op, 0, 1'b1, 1'b0, 1));
        // Two ops back-to-back; done during ISSUE is ignored.
        vecs.push_back(mk_vec(1'b1, a_op, 1'b0, n_op, 1, 1'b1, 1'b1, 1));
        vecs.push_back(mk_vec(1'b1, b_op, 1'b0, n_op, 2, 1'b1, 1'b1, 1));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, a_op, 1, 1'b1, 1'b1, 1));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 1, 1'b1, 1'b1, 1));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, n_op, 1, 1'b1, 1'b1, 1));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 1, 1'b1, 1'b1, 2));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, b_op, 0, 1'b1, 1'b1, 2));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, n_op, 0, 1'b1, 1'b1, 2));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b0, 3));
        // NO_OP enqueue is dropped; done pulse in IDLE is ignored.
        vecs.push_back(mk_vec(1'b1, z_op, 1'b0, n_op, 0, 1'b1, 1'b0, 3));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b0, 3));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b1, n_op, 0, 1'b1, 1'b0, 3));
        vecs.push_back(mk_vec(1'b0, n_op, 1'b0, n_op, 0, 1'b1, 1'b0, 3));

        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_op    = n_op;
        cpu_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk) reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            enq_valid = vecs[i].ev;
            enq_op    = vecs[i].op;
            cpu_done  = vecs[i].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  80'({cpu_op, count, enq_ready, busy, retired_cnt}),
                  80'({vecs[i].exp_op, vecs[i].exp_cnt, vecs[i].exp_rdy, vecs[i].exp_busy, vecs[i].exp_ret}));
        end
        @(negedge clk);
        enq_valid = 1'b0;
        cpu_done  = 1'b0;

        // Stalled cpu: first op pops, next eight fill the queue, a tenth is held off.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            enq_valid = 1'b1;
            enq_op    = fill_op(i);
            @(posedge clk);
            #1;
            if (i == 2) check("fill_first_issue", 80'(cpu_op), 80'(fill_op(0)));
        end
        check("full_count", 80'(count), 80'(4'd8));
        check("full_ready", 80'(enq_ready), 80'(1'b0));
        @(negedge clk);
        enq_op = fill_op(9);
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_count", 80'(count), 80'(4'd8));
        check("full_hold_ready", 80'(enq_ready), 80'(1'b0));
        @(negedge clk) enq_valid = 1'b0;
        complete();
        for (int k = 1; k < 9; k++) begin
            wait_issue(fill_op(k), $sformatf("drain%0d", k));
            complete();
        end
        @(posedge clk);
        #1;
        check("drain_retired", 80'(retired_cnt), 80'(16'd12));
        check("drain_count", 80'(count), 80'(4'd0));
        check("drain_busy", 80'(busy), 80'(1'b0));

        // Cpu never answers.
        @(negedge clk);
        enq_valid = 1'b1;
        enq_op    = a_op;
        @(negedge clk) enq_op = b_op;
        @(negedge clk) enq_valid = 1'b0;
        wait_issue(a_op, "hang_issue_a");
`ifdef ISSUE_TIMEOUT_EN
        repeat (15) @(posedge clk);
        #1;
        check("timeout_not_yet", 80'(err_timeout), 80'(1'b0));
        @(posedge clk);
        #1;
        check("timeout_fired", 80'(err_timeout), 80'(1'b1));
        wait_issue(b_op, "timeout_next_issue");
        check("timeout_no_retire", 80'(retired_cnt), 80'(16'd12));
        check("timeout_sticky", 80'(err_timeout), 80'(1'b1));
`else
        repeat (40) @(posedge clk);
        #1;
        check("hang_err", 80'(err_timeout), 80'(1'b0));
        check("hang_cpu_op", 80'(cpu_op), 80'(n_op));
        check("hang_busy", 80'(busy), 80'(1'b1));
        check("hang_count", 80'(count), 80'(4'd1));
        check("hang_retired", 80'(retired_cnt), 80'(16'd12));
`endif

        // Reset while WAITing abandons the op and flushes the queue.
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midwait");
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("flush_cpu_op", 80'(cpu_op), 80'(n_op));
        check("flush_busy", 80'(busy), 80'(1'b0));
        check("flush_count", 80'(count), 80'(4'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
